// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : router_pkg
//  Description : Shared widths, constants and FSM encoding for the router
//                packet transmitter and its parity accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    // Destination 3 does not exist on the router.
    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        GAP     = 3'd4
    } tx_state_e;

    // A start request is only honoured for a real port and a non-empty payload.
    function automatic logic start_legal(input logic [ADDR_W-1:0] addr,
                                         input logic [LEN_W-1:0]  len);
        return (addr != ADDR_ILLEGAL) && (len != '0);
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_parity_acc.sv
`default_nettype none
// ============================================================================
//  Module      : router_parity_acc
//  Description : Running XOR of every byte handed to the router. Cleared when
//                a new packet is launched, updated on each accepted byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_parity_acc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] parity_o
);

    logic [BYTE_W-1:0] acc_q;

    // Clear has priority so a fresh packet never inherits stale parity.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ byte_i;
        end
    end

    assign parity_o = acc_q;

endmodule : router_parity_acc
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_tx
//  Description : Packet transmitter toward the router: header, payload bytes
//                streamed from din, trailing parity byte, one-cycle gap.
//                Optional macro ROUTER_PKT_TX_ERR_INJ_EN enables inverted
//                parity when corrupt_parity is latched with start.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic [BYTE_W-1:0] din,
    input  logic              corrupt_parity,
    input  logic              busy,
    output logic              din_req,
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              tx_ready,
    output logic              tx_err,
    output logic              tx_done
);

    tx_state_e         state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] data_q;
    logic              pkt_valid_q;
    logic              tx_ready_q;
    logic              tx_err_q;
    logic              tx_done_q;

    logic              start_ok;
    logic              launch;
    logic              acc_en;
    logic [BYTE_W-1:0] acc_byte;
    logic [BYTE_W-1:0] acc_parity;
    logic [BYTE_W-1:0] parity_d;
    logic [BYTE_W-1:0] parity_tx;
    logic [BYTE_W-1:0] header_byte;

    assign start_ok    = start && start_legal(dest_addr, pay_len);
    assign launch      = (state_q == IDLE) && start_ok;
    assign header_byte = {len_q, addr_q};

    // Header and payload bytes feed the accumulator only when the router takes them.
    assign acc_en   = !busy && ((state_q == HEADER) || (state_q == PAYLOAD));
    assign acc_byte = (state_q == HEADER) ? header_byte : din;

    router_parity_acc u_parity_acc (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (launch),
        .en_i     (acc_en),
        .byte_i   (acc_byte),
        .parity_o (acc_parity)
    );

    // The last payload byte is folded in here so the parity register is ready
    // on the very edge that enters PARITY.
    assign parity_d = acc_parity ^ din;

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    logic corrupt_q;

    // Injection request is captured with the accepted start only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            corrupt_q <= 1'b0;
        end else if (launch) begin
            corrupt_q <= corrupt_parity;
        end
    end

    assign parity_tx = corrupt_q ? ~parity_d : parity_d;
`else
    logic unused_corrupt;
    assign unused_corrupt = corrupt_parity;
    assign parity_tx      = parity_d;
`endif

    // Packet sequencing FSM; all control outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_err_q    <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_err_q  <= 1'b0;
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        len_q       <= pay_len;
                        addr_q      <= dest_addr;
                        cnt_q       <= pay_len;
                        pkt_valid_q <= 1'b1;
                        tx_ready_q  <= 1'b0;
                        state_q     <= HEADER;
                    end else if (start) begin
                        tx_err_q <= 1'b1;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == 6'd1) begin
                            pkt_valid_q <= 1'b0;
                            data_q      <= parity_tx;
                            state_q     <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_q    <= '0;
                        tx_done_q <= 1'b1;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    data_q      <= '0;
                    pkt_valid_q <= 1'b0;
                    tx_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Payload bytes flow straight from din; every other state shows a register.
    always_comb begin
        din_req  = 1'b0;
        data_out = data_q;
        if (state_q == PAYLOAD) begin
            din_req  = !busy;
            data_out = din;
        end else if (state_q == HEADER) begin
            data_out = header_byte;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign tx_ready  = tx_ready_q;
    assign tx_err    = tx_err_q;
    assign tx_done   = tx_done_q;

endmodule : router_pkt_tx
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_pkt_tx
//  Description : Self-checking bench for router_pkt_tx. A packet is modelled
//                as the byte list header, payload..., parity; the bench walks
//                that list, advancing only on cycles where busy is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] din;
    logic       corrupt_parity;
    logic       busy;
    logic       din_req;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_ready;
    logic       tx_err;
    logic       tx_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] payload [64];

    router_pkt_tx dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .dest_addr      (dest_addr),
        .pay_len        (pay_len),
        .din            (din),
        .corrupt_parity (corrupt_parity),
        .busy           (busy),
        .din_req        (din_req),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .tx_ready       (tx_ready),
        .tx_err         (tx_err),
        .tx_done        (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs expected whenever the transmitter is idle with nothing pending.
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, tx_ready, 1);
        chk({tag, "_valid"}, pkt_valid, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_dreq"}, din_req, 0);
        chk({tag, "_err"}, tx_err, 0);
        chk({tag, "_done"}, tx_done, 0);
    endtask

    // Sends one packet from payload[]; stall_idx/stall_n force busy on one list
    // entry, stall_pct adds random busy, abort_idx resets on reaching an entry.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] len, input bit corr,
                            input int stall_pct, input int stall_idx, input int stall_n,
                            input int abort_idx, output logic [7:0] par_seen);
        logic [7:0] seq [66];
        logic [7:0] par;
        int idx, cycles, stall_left;
        bit parity_seen;
        seq[0] = {len, a};
        par = seq[0];
        for (int i = 1; i <= int'(len); i++) begin
            seq[i] = payload[i-1];
            par ^= payload[i-1];
        end
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        if (corr) par = ~par;
`endif
        seq[int'(len)+1] = par;
        par_seen = 8'hxx;
        parity_seen = 0;

        @(negedge clk);
        start = 1; dest_addr = a; pay_len = len; corrupt_parity = corr;
        busy = 1'($urandom); din = 8'($urandom);
        #1;
        chk("start_ready", tx_ready, 1);
        chk("start_valid", pkt_valid, 0);

        idx = 0; cycles = 0; stall_left = stall_n;
        @(negedge clk);
        while (idx <= int'(len) + 1 && cycles < 2000) begin
            if (idx == abort_idx) begin
                resetn = 0; start = 0; busy = 0;
                #1;
                chk_idle("abort");
                @(negedge clk);
                resetn = 1;
                #1;
                chk_idle("post_abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    chk("abort_no_done", tx_done, 0);
                    chk("abort_no_valid", pkt_valid, 0);
                end
                return;
            end
            // Starts with arbitrary fields while a packet is in flight must be ignored.
            start = 1'($urandom); dest_addr = 2'($urandom);
            pay_len = 6'($urandom); corrupt_parity = 1'($urandom);
            if (idx == stall_idx && stall_left > 0) begin
                busy = 1; stall_left--;
            end else begin
                busy = ($urandom_range(0, 99) < stall_pct);
            end
            din = (idx >= 1 && idx <= int'(len)) ? payload[idx-1] : 8'($urandom);
            #1;
            chk("pkt_data", data_out, seq[idx]);
            chk("pkt_valid", pkt_valid, (idx <= int'(len)) ? 1 : 0);
            chk("pkt_dreq", din_req, (idx >= 1 && idx <= int'(len) && !busy) ? 1 : 0);
            chk("pkt_ready", tx_ready, 0);
            chk("pkt_err", tx_err, 0);
            chk("pkt_done", tx_done, 0);
            if (idx == int'(len) + 1) begin
                par_seen = data_out;
                parity_seen = 1;
            end
            if (!busy) idx++;
            cycles++;
            @(negedge clk);
        end
        chk("pkt_timeout", (cycles < 2000) ? 1 : 0, 1);
        chk("parity_reached", parity_seen, 1);
        // Gap cycle: done pulse, bus quiet, still not ready.
        start = 0; busy = 1'($urandom);
        #1;
        chk("gap_done", tx_done, 1);
        chk("gap_valid", pkt_valid, 0);
        chk("gap_data", data_out, 0);
        chk("gap_ready", tx_ready, 0);
        @(negedge clk);
        #1;
        chk_idle("after_gap");
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] len);
        @(negedge clk);
        start = 1; dest_addr = a; pay_len = len; busy = 0;
        #1;
        chk("bad_ready_pre", tx_ready, 1);
        chk("bad_err_pre", tx_err, 0);
        @(negedge clk);
        start = 0;
        #1;
        chk("bad_err_pulse", tx_err, 1);
        chk("bad_valid", pkt_valid, 0);
        chk("bad_ready", tx_ready, 1);
        @(negedge clk);
        #1;
        chk("bad_err_clear", tx_err, 0);
        chk("bad_ready_post", tx_ready, 1);
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] exp_par;
        logic [1:0] ra;
        logic [5:0] rl;

        resetn = 0; start = 0; dest_addr = 0; pay_len = 0;
        din = 0; corrupt_parity = 0; busy = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        resetn = 1;
        #1;
        chk_idle("reset_release");

        // Reference packet: addr 1, three bytes, parity = XOR of header and payload.
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        exp_par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 0, -1, par);
        chk("ref_parity", par, exp_par);

        // Same packet stalled three cycles on the second payload byte.
        send_pkt(2'd1, 6'd3, 1'b0, 0, 2, 3, -1, par);
        chk("stall_parity", par, exp_par);

        // Same packet with injection requested.
        send_pkt(2'd1, 6'd3, 1'b1, 0, -1, 0, -1, par);
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        chk("inj_parity", par, ~exp_par);
`else
        chk("inj_parity", par, exp_par);
`endif

        // Rejected starts.
        bad_start(2'd3, 6'd5);
        bad_start(2'd0, 6'd0);

        // Reset in the middle of a 10-byte payload, then a clean packet.
        for (int i = 0; i < 10; i++) payload[i] = 8'($urandom);
        send_pkt(2'd2, 6'd10, 1'b0, 0, -1, 0, 5, par);
        send_pkt(2'd2, 6'd10, 1'b0, 20, -1, 0, -1, par);

        // Boundary lengths.
        payload[0] = 8'hA5;
        send_pkt(2'd0, 6'd1, 1'b0, 30, -1, 0, -1, par);
        for (int i = 0; i < 63; i++) payload[i] = 8'($urandom);
        send_pkt(2'd2, 6'd63, 1'b0, 10, -1, 0, -1, par);

        // Randomized packets interleaved with occasional illegal starts.
        for (int n = 0; n < 20; n++) begin
            ra = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 20));
            for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
            send_pkt(ra, rl, 1'($urandom), 30, -1, 0, -1, par);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) bad_start(2'd3, 6'($urandom_range(1, 63)));
                else bad_start(2'($urandom_range(0, 2)), 6'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_router_pkt_tx
`default_nettype wire
